// File: rtl/term_tx_sched.sv
// Output scheduler for the video terminal: buffers CPU $D012 writes in a FIFO and
// shares the terminal's te/ti input round-robin with one auxiliary character source.
module term_tx_sched #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic [7:0]                 cpu_data,
  output logic                       cpu_full,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     fifo_count,
  input  logic                       aux_valid,
  input  logic [7:0]                 aux_data,
  output logic                       aux_ready,
  input  logic                       tready,
  output logic                       te,
  output logic [6:0]                 ti
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_AUX = 1'b1
  } src_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  src_t          last;

  logic          te_q;
  logic          aux_ready_q;
  logic [6:0]    ti_q;

  logic          cpu_cand;
  logic          aux_cand;
  logic          grant_cpu;
  logic          grant_aux;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          unused_bits;

  assign head     = mem[rptr];
  assign cpu_cand = (count != '0);
  assign aux_cand = aux_valid;

  // Contention goes to whichever source did not win last time.
  assign grant_cpu = tready && cpu_cand && (!aux_cand || (last == SRC_AUX));
  assign grant_aux = tready && aux_cand && (!cpu_cand || (last == SRC_CPU));

  assign pop  = grant_cpu;
  assign push = cpu_we && ((count != FULL_CNT) || pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + ONE_CNT;
      2'b01:   count_nxt = count - ONE_CNT;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      cpu_full    <= 1'b0;
      ovf         <= 1'b0;
      last        <= SRC_AUX;
      te_q        <= 1'b0;
      aux_ready_q <= 1'b0;
      ti_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= cpu_data;
        wptr      <= wptr + ONE_PTR;
      end
      if (pop) begin
        rptr <= rptr + ONE_PTR;
      end
      count    <= count_nxt;
      cpu_full <= (count_nxt == FULL_CNT);
      if (cpu_we && !push) begin
        ovf <= 1'b1;
      end

      te_q        <= grant_cpu || grant_aux;
      aux_ready_q <= grant_aux;
      if (grant_cpu) begin
        ti_q <= head[6:0];
        last <= SRC_CPU;
      end else if (grant_aux) begin
        ti_q <= aux_data[6:0];
        last <= SRC_AUX;
      end
    end
  end

  // Reset held in the cycle after a grant must still swallow the pending strobe,
  // so the two pulse outputs are masked by reset rather than waiting for the edge.
  assign te         = te_q & ~reset;
  assign aux_ready  = aux_ready_q & ~reset;
  assign ti         = ti_q;
  assign fifo_count = count;

  assign unused_bits = ^{aux_data[7], head[7]};

endmodule

// File: tb/tb_term_tx_sched.sv
// Directed self-checking bench for term_tx_sched: reset, single char, overflow,
// round-robin, full push+pop and reset in the issue cycle.
module tb_term_tx_sched;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_we;
  logic [7:0] cpu_data;
  logic       cpu_full;
  logic       ovf;
  logic [3:0] fifo_count;
  logic       aux_valid;
  logic [7:0] aux_data;
  logic       aux_ready;
  logic       tready;
  logic       te;
  logic [6:0] ti;

  int tests = 0;
  int fails = 0;

  term_tx_sched #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .cpu_full   (cpu_full),
    .ovf        (ovf),
    .fifo_count (fifo_count),
    .aux_valid  (aux_valid),
    .aux_data   (aux_data),
    .aux_ready  (aux_ready),
    .tready     (tready),
    .te         (te),
    .ti         (ti)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_we = 1'b0; aux_valid = 1'b0; tready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    cpu_we = 1'b1; cpu_data = d;
    cyc();
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_we = 1'b1; cpu_data = 8'hFF;
    aux_valid = 1'b1; aux_data = 8'h55; tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      tests++;
      if ({te, ti, aux_ready, cpu_full, ovf, fifo_count} !== 15'd0) begin
        fails++;
        $display("FAIL reset_c%0d: te=%b ti=%h aux_ready=%b full=%b ovf=%b cnt=%0d, required all 0",
                 i, te, ti, aux_ready, cpu_full, ovf, fifo_count);
      end
    end
    reset = 1'b0; cpu_we = 1'b0; aux_valid = 1'b0;
  endtask

  task automatic test_single_char();
    bit seen;
    do_reset();
    write_byte(8'hC1);
    tests++;
    if (fifo_count !== 4'd1) begin
      fails++; $display("FAIL single_count_push: got %0d, required 1", fifo_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (te) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL single_no_te_without_tready: te seen=%b, required 0", seen);
    end
    tready = 1'b1;
    cyc();
    tready = 1'b0;
    tests++;
    if (te !== 1'b1 || ti !== 7'h41) begin
      fails++; $display("FAIL single_issue: te=%b ti=%h, required te=1 ti=41", te, ti);
    end
    tests++;
    if (fifo_count !== 4'd0) begin
      fails++; $display("FAIL single_count_pop: got %0d, required 0", fifo_count);
    end
    cyc();
    tests++;
    if (te !== 1'b0) begin
      fails++; $display("FAIL single_te_width: te=%b one cycle later, required 0", te);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      write_byte(8'(8'h30 + i));
      if (i == 7) begin
        tests++;
        if (cpu_full !== 1'b1 || ovf !== 1'b0) begin
          fails++; $display("FAIL ovf_full_after_8: full=%b ovf=%b, required full=1 ovf=0", cpu_full, ovf);
        end
      end
      if (i == 8) begin
        tests++;
        if (ovf !== 1'b1 || fifo_count !== 4'd8) begin
          fails++; $display("FAIL ovf_after_9: ovf=%b cnt=%0d, required ovf=1 cnt=8", ovf, fifo_count);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      tready = 1'b1;
      cyc();
      tready = 1'b0;
      tests++;
      if (te !== 1'b1 || ti !== 7'(8'h30 + i)) begin
        fails++; $display("FAIL ovf_drain_%0d: te=%b ti=%h, required te=1 ti=%h", i, te, ti, 7'(8'h30 + i));
      end
      if (i == 0) begin
        tests++;
        if (cpu_full !== 1'b0) begin
          fails++; $display("FAIL ovf_full_drop: full=%b, required 0", cpu_full);
        end
      end
      cyc();
    end
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests++;
      if (te !== 1'b0) begin
        fails++; $display("FAIL ovf_dropped_byte_%0d: te=%b ti=%h, required te=0", i, te, ti);
      end
    end
    tready = 1'b0;
    tests++;
    if (ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: ovf=%b, required 1", ovf);
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_ti [4];
    logic       exp_ar [4];
    exp_ti = '{7'h41, 7'h5A, 7'h42, 7'h5A};
    exp_ar = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    write_byte(8'h41);
    write_byte(8'h42);
    aux_valid = 1'b1; aux_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      tready = 1'b1;
      cyc();
      tready = 1'b0;
      tests++;
      if (te !== 1'b1 || ti !== exp_ti[i] || aux_ready !== exp_ar[i]) begin
        fails++; $display("FAIL rr_%0d: te=%b ti=%h aux_ready=%b, required te=1 ti=%h aux_ready=%b",
                          i, te, ti, aux_ready, exp_ti[i], exp_ar[i]);
      end
      cyc();
    end
    aux_valid = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) write_byte(8'(8'h50 + i));
    tready = 1'b1; cpu_we = 1'b1; cpu_data = 8'h58;
    cyc();
    tready = 1'b0; cpu_we = 1'b0;
    tests++;
    if (te !== 1'b1 || ti !== 7'h50 || fifo_count !== 4'd8 || ovf !== 1'b0 || cpu_full !== 1'b1) begin
      fails++; $display("FAIL fpp_grant: te=%b ti=%h cnt=%0d ovf=%b full=%b, required te=1 ti=50 cnt=8 ovf=0 full=1",
                        te, ti, fifo_count, ovf, cpu_full);
    end
    cyc();
    for (int i = 1; i <= 8; i++) begin
      tready = 1'b1;
      cyc();
      tready = 1'b0;
      tests++;
      if (te !== 1'b1 || ti !== 7'(8'h50 + i)) begin
        fails++; $display("FAIL fpp_order_%0d: te=%b ti=%h, required te=1 ti=%h", i, te, ti, 7'(8'h50 + i));
      end
      cyc();
    end
    tests++;
    if (ovf !== 1'b0 || fifo_count !== 4'd0) begin
      fails++; $display("FAIL fpp_end: ovf=%b cnt=%0d, required ovf=0 cnt=0", ovf, fifo_count);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    write_byte(8'h61);
    write_byte(8'h63);
    tready = 1'b1;
    cyc();
    tready = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if (te !== 1'b0 || aux_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_te: te=%b aux_ready=%b, required both 0", te, aux_ready);
    end
    cyc();
    reset = 1'b0;
    tests++;
    if (fifo_count !== 4'd0 || te !== 1'b0 || ti !== 7'h00) begin
      fails++; $display("FAIL mid_reset_state: cnt=%0d te=%b ti=%h, required cnt=0 te=0 ti=00", fifo_count, te, ti);
    end
    write_byte(8'h62);
    tready = 1'b1;
    cyc();
    tready = 1'b0;
    tests++;
    if (te !== 1'b1 || ti !== 7'h62) begin
      fails++; $display("FAIL mid_reset_next: te=%b ti=%h, required te=1 ti=62", te, ti);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_overflow();
    test_round_robin();
    test_full_push_pop();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
